synq_fifo_v2: RTL and testbench
===============================

// Module: synq_fifo_v2
// PURPOSE
//  Parametrised synchronous FIFO, next generation of the single-clock FIFO used between UART RX/TX and core logic.
//  Adds synchronous reset, occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow
//  error flags, non-power-of-2 depth, and simultaneous read/write when full. Single clock domain.
// PARAMETERS
//  DATA_WIDTH  8   width of each stored word
//  DEPTH       32  number of entries; any value >= 2 (power of 2 not required)
//  AF_THRESH   28  almost_full asserted when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH   4   almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
// PORTS
//  clk           in   1                    rising-edge clock
//  rst           in   1                    synchronous, active-high reset
//  wr_en         in   1                    write request
//  wr_data       in   DATA_WIDTH           write data
//  rd_en         in   1                    read request
//  rd_data       out  DATA_WIDTH           read data
//  rd_valid      out  1                    rd_data holds newly popped word (see BEHAVIOUR)
//  f_full        out  1                    count == DEPTH
//  f_empty       out  1                    count == 0
//  almost_full   out  1                    count >= AF_THRESH
//  almost_empty  out  1                    count <= AE_THRESH
//  count         out  $clog2(DEPTH+1)      current occupancy
//  overflow      out  1                    sticky: write was rejected
//  underflow     out  1                    sticky: read was rejected
//  err_clr       in   1                    synchronous clear of overflow/underflow
// BEHAVIOUR
//  - Reset (rst=1 at posedge): ptrs=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0; hence f_empty=1,
//    f_full=0, almost_empty=1, almost_full=0 (AF_THRESH>=1). Memory contents are not cleared. rst overrides all.
//  - rd_acc = rd_en & ~f_empty;  wr_acc = wr_en & (~f_full | rd_acc).  Write while full is accepted only with a
//    simultaneous accepted read; write while empty + read request: write accepted, read rejected.
//  - count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both. Flags decode the count register, so they
//    change the cycle after the accepting edge. count never exceeds DEPTH or goes below 0.
//  - Pointers: increment on accept; wrap from DEPTH-1 to 0 explicitly (no reliance on binary overflow).
//  - rd_data (default mode): registered; loads mem[rd_ptr] on rd_acc, visible the cycle after; rd_valid=1 for
//    exactly that cycle. With no rd_acc, rd_data HOLDS its last value (never forced to 0).
//  - Read and write of same slot in one cycle (full, both accepted): read returns old word; write stores new one.
//  - overflow set on wr_en & ~wr_acc; underflow set on rd_en & ~rd_acc; both hold until rst or err_clr.
//    Same-cycle err_clr and new error: error wins (flag stays 1).
//  - Rejected operations change no pointer, count or memory.
// CONFIGURATION
//  SYNQ_FIFO_FWFT_EN defined: first-word-fall-through. rd_data presents mem[rd_ptr] whenever f_empty=0 with no
//  rd_en needed; rd_valid = ~f_empty; rd_en pops (acknowledge). A word written to an empty FIFO appears on
//  rd_data/rd_valid the cycle after the write edge. When empty rd_data holds its last value.
//  Not defined: registered-read behaviour above (1-cycle latency after rd_acc).
// STRUCTURE
//  - Shared package synq_fifo_pkg: default DATA_WIDTH/DEPTH constants, function for count width
//    ($clog2(DEPTH+1)), pointer-wrap helper.
//  - One sub-module: synq_fifo_mem - simple dual-port array (1 sync write port, 1 read port; registered read in
//    default mode, async read in FWFT mode). Control, pointers, count and flags stay in synq_fifo_v2.
// TESTING  (DATA_WIDTH=8, DEPTH=5, AF_THRESH=4, AE_THRESH=1 unless stated)
//  - Reset: assert rst 2 cycles mid-traffic -> count=0, f_empty=1, almost_empty=1, rd_valid=0, rd_data=0, errs=0.
//  - Fill: write 0x11..0x15 -> count steps 1..5, almost_empty drops at count=2, almost_full at 4, f_full at 5;
//    6th write 0x16 -> rejected, overflow=1, count=5; err_clr -> overflow=0.
//  - Drain: read 5 times -> rd_data 0x11..0x15 each 1 cycle after rd_en with rd_valid pulse; 6th read ->
//    underflow=1, rd_data stays 0x15, rd_valid=0.
//  - Full + simultaneous rd/wr 0xAA -> count stays 5, no overflow, 0xAA read out last (wrap across slot 4->0).
//  - Empty + simultaneous rd/wr 0x3C -> count=1, underflow=1; next read returns 0x3C.
//  - FWFT build: write 0x5A to empty -> next cycle rd_data=0x5A, rd_valid=1 without rd_en; rd_en -> f_empty=1.

Source files
------------

// File: rtl/synq_fifo_pkg.sv
// Shared constants and helpers for the synq_fifo family.
// Consumed by synq_fifo_v2 and synq_fifo_mem.
package synq_fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_DEPTH      = 32;

    // Occupancy counter must be able to represent DEPTH itself.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Explicit wrap so non-power-of-2 depths work.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/synq_fifo_mem.sv
// Simple dual-port storage for synq_fifo_v2: one synchronous write port, one read port.
// Read port is registered by default, combinational when SYNQ_FIFO_FWFT_EN is defined.
module synq_fifo_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

`ifdef SYNQ_FIFO_FWFT_EN
    logic unused_ctrl;
    assign unused_ctrl = rd_en ^ rst;
    assign rd_data     = mem_q[rd_addr];
`else
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Non-blocking read sees the pre-write word when both ports hit the same slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: rtl/synq_fifo_v2.sv
// Single-clock FIFO with occupancy count, programmable almost flags and sticky error flags.
// Define SYNQ_FIFO_FWFT_EN for first-word-fall-through reads; default is 1-cycle registered read.
module synq_fifo_v2
    import synq_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned AF_THRESH  = 28,
    parameter int unsigned AE_THRESH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          rd_en,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_valid,
    output logic                          f_full,
    output logic                          f_empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          overflow,
    output logic                          underflow,
    input  logic                          err_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = count_width(DEPTH);

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  rd_acc, wr_acc;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    assign f_full       = (count_q == CW'(DEPTH));
    assign f_empty      = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // A write into a full FIFO is only legal when a read frees a slot in the same cycle.
    assign rd_acc = rd_en & ~f_empty;
    assign wr_acc = wr_en & (~f_full | rd_acc);

    always_comb begin
        wr_ptr_d = wr_acc ? AW'(ptr_inc(32'(wr_ptr_q), DEPTH)) : wr_ptr_q;
        rd_ptr_d = rd_acc ? AW'(ptr_inc(32'(rd_ptr_q), DEPTH)) : rd_ptr_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A new error in the clearing cycle keeps the flag set.
        ovf_d = (ovf_q & ~err_clr) | (wr_en & ~wr_acc);
        udf_d = (udf_q & ~err_clr) | (rd_en & ~rd_acc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    synq_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr_q),
        .rd_data (mem_rd_data)
    );

`ifdef SYNQ_FIFO_FWFT_EN
    logic [DATA_WIDTH-1:0] hold_q;

    // Tracks the presented head word so rd_data keeps it once the FIFO drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else if (!f_empty) begin
            hold_q <= mem_rd_data;
        end
    end

    assign rd_data  = f_empty ? hold_q : mem_rd_data;
    assign rd_valid = ~f_empty;
`else
    logic rd_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
        end
    end

    assign rd_data  = mem_rd_data;
    assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_synq_fifo_v2.sv
// Directed self-checking bench for synq_fifo_v2 (DEPTH=5, AF_THRESH=4, AE_THRESH=1).
// Covers the registered-read build by default and the FWFT build when SYNQ_FIFO_FWFT_EN is defined.
module tb_synq_fifo_v2;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       f_full;
    logic       f_empty;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;
    logic       err_clr;

    int n_checks = 0;
    int n_errors = 0;

    synq_fifo_v2 #(
        .DATA_WIDTH (8),
        .DEPTH      (5),
        .AF_THRESH  (4),
        .AE_THRESH  (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .f_full       (f_full),
        .f_empty      (f_empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, " count"},        32'(count),        32'd0);
        check_val({tag, " f_empty"},      32'(f_empty),      32'd1);
        check_val({tag, " f_full"},       32'(f_full),       32'd0);
        check_val({tag, " almost_empty"}, 32'(almost_empty), 32'd1);
        check_val({tag, " almost_full"},  32'(almost_full),  32'd0);
        check_val({tag, " rd_valid"},     32'(rd_valid),     32'd0);
        check_val({tag, " rd_data"},      32'(rd_data),      32'd0);
        check_val({tag, " overflow"},     32'(overflow),     32'd0);
        check_val({tag, " underflow"},    32'(underflow),    32'd0);
    endtask

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    logic [7:0] exp_fill_ae [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] exp_fill_af [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] exp_drain   [5] = '{8'h22, 8'h23, 8'h24, 8'h25, 8'hAA};

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_reset_state("init");

`ifdef SYNQ_FIFO_FWFT_EN
        push(8'h5A);
        check_val("fwft first rd_data",  32'(rd_data),  32'h5A);
        check_val("fwft first rd_valid", 32'(rd_valid), 32'd1);
        check_val("fwft first count",    32'(count),    32'd1);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check_val("fwft pop f_empty",  32'(f_empty),  32'd1);
        check_val("fwft pop rd_valid", 32'(rd_valid), 32'd0);
        check_val("fwft hold rd_data", 32'(rd_data),  32'h5A);
        push(8'h61);
        push(8'h62);
        check_val("fwft head 0x61", 32'(rd_data), 32'h61);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check_val("fwft head 0x62",  32'(rd_data), 32'h62);
        check_val("fwft count 1",    32'(count),   32'd1);
        rd_en = 1'b1;
        step();
        step();
        rd_en = 1'b0;
        check_val("fwft underflow",   32'(underflow), 32'd1);
        check_val("fwft hold 0x62",   32'(rd_data),   32'h62);
`else
        // Fill 0x11..0x15; almost_empty drops at 2, almost_full at 4, full at 5.
        for (int i = 0; i < 5; i++) begin
            push(8'h11 + 8'(i));
            check_val($sformatf("fill%0d count", i), 32'(count), 32'(i + 1));
            check_val($sformatf("fill%0d ae", i), 32'(almost_empty), 32'(i == 0));
            check_val($sformatf("fill%0d af", i), 32'(almost_full), 32'(exp_fill_af[i]));
            check_val($sformatf("fill%0d full", i), 32'(f_full), 32'(i == 4));
        end
        check_val("fill ae stays low", 32'(almost_empty), 32'(exp_fill_ae[4]));
        push(8'h16);
        check_val("ovf flag",  32'(overflow), 32'd1);
        check_val("ovf count", 32'(count),    32'd5);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_val("ovf cleared", 32'(overflow), 32'd0);

        for (int i = 0; i < 5; i++) begin
            rd_en = 1'b1;
            step();
            check_val($sformatf("drain%0d data", i), 32'(rd_data), 32'h11 + 32'(i));
            check_val($sformatf("drain%0d valid", i), 32'(rd_valid), 32'd1);
            check_val($sformatf("drain%0d count", i), 32'(count), 32'(4 - i));
        end
        step();
        rd_en = 1'b0;
        check_val("udf flag",     32'(underflow), 32'd1);
        check_val("udf rd_data",  32'(rd_data),   32'h15);
        check_val("udf rd_valid", 32'(rd_valid),  32'd0);
        step();
        check_val("idle hold rd_data", 32'(rd_data), 32'h15);
        rd_en   = 1'b1;
        err_clr = 1'b1;
        step();
        rd_en   = 1'b0;
        err_clr = 1'b0;
        check_val("err wins over clr", 32'(underflow), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_val("udf cleared", 32'(underflow), 32'd0);

        // Pointers are at slot 0; simultaneous rd/wr when full hits the same slot.
        for (int i = 0; i < 5; i++) push(8'h21 + 8'(i));
        wr_en   = 1'b1;
        wr_data = 8'hAA;
        rd_en   = 1'b1;
        step();
        wr_en   = 1'b0;
        check_val("full rw count",   32'(count),    32'd5);
        check_val("full rw ovf",     32'(overflow), 32'd0);
        check_val("full rw old word", 32'(rd_data), 32'h21);
        for (int i = 0; i < 5; i++) begin
            step();
            check_val($sformatf("wrap drain%0d", i), 32'(rd_data), 32'(exp_drain[i]));
        end
        rd_en = 1'b0;
        check_val("wrap drain empty", 32'(f_empty), 32'd1);

        wr_en   = 1'b1;
        wr_data = 8'h3C;
        rd_en   = 1'b1;
        step();
        wr_en   = 1'b0;
        check_val("empty rw count",    32'(count),     32'd1);
        check_val("empty rw udf",      32'(underflow), 32'd1);
        check_val("empty rw rd_valid", 32'(rd_valid),  32'd0);
        step();
        rd_en = 1'b0;
        check_val("empty rw readback", 32'(rd_data),  32'h3C);
        check_val("empty rw valid",    32'(rd_valid), 32'd1);
`endif

        // Reset in the middle of traffic with an error flag pending.
        push(8'h77);
        push(8'h78);
        wr_en   = 1'b1;
        wr_data = 8'h79;
        rd_en   = 1'b1;
        rst     = 1'b1;
        step();
        step();
        rst     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        check_reset_state("midrst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
